fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it reads the 16-bit word at the current PC from instruction memory and assembles 16-bit or 32-bit instructions (opcode word plus immediate word).
- It loads the IF/ID pipeline register consumed by decode.
- It drives pc_hold back to the PC so the PC source selects "old pc" while fetch is stalled.

Parameters:
- INSTR_W, 16, instruction memory word width.
- PC_W, 32, program counter width.
- IMM_FLAG_BIT, 0, bit of the first word that marks a two-word (immediate) instruction.
- NOP_WORD, 16'h0000, encoding injected on bubble or flush.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- pc  in  PC_W  current PC; stable at posedge because the PC updates on negedge.
- imem_data  in  INSTR_W  combinational instruction-memory read of address pc.
- stall  in  1  decode/hazard stall request.
- flush  in  1  branch/interrupt/ret squash request.
- pc_hold  out  1  to PC: hold current address.
- if_id_instr  out  INSTR_W  registered opcode word.
- if_id_imm  out  INSTR_W  registered immediate word (0 for one-word instructions).
- if_id_pc  out  PC_W  address of the opcode word.
- if_id_next_pc  out  PC_W  address after the last fetched word (return address for call).
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset==0 at posedge):
  - state=OPCODE.
  - if_id_instr=NOP_WORD, if_id_imm=0, if_id_pc=0, if_id_next_pc=0, if_id_valid=0.
  - Internal hold registers cleared.
  - Reset overrides flush and stall.
- pc_hold is combinational: pc_hold = stall & ~flush. It is 0 during reset.
- Priority at each posedge: reset > flush > stall > normal fetch.
- flush:
  - if_id_instr=NOP_WORD, if_id_imm=0, if_id_valid=0.
  - if_id_pc and if_id_next_pc hold their values.
  - state->OPCODE; any held opcode word is discarded.
  - flush during SECOND drops the partial instruction.
- stall (no flush): all registers and state hold; imem_data is ignored.
- State OPCODE, normal fetch:
  - If imem_data[IMM_FLAG_BIT]==0:
    - if_id_instr=imem_data, if_id_imm=0, if_id_pc=pc, if_id_next_pc=pc+1, if_id_valid=1.
    - Stay in OPCODE.
  - If imem_data[IMM_FLAG_BIT]==1:
    - Latch op_hold=imem_data and pc_hold_reg=pc.
    - Output bubble: if_id_instr=NOP_WORD, if_id_valid=0.
    - state->SECOND.
- State SECOND, normal fetch:
  - if_id_instr=op_hold, if_id_imm=imem_data, if_id_pc=pc_hold_reg, if_id_next_pc=pc+1, if_id_valid=1.
  - state->OPCODE.
  - The immediate word's IMM_FLAG_BIT is not interpreted.
- Latency:
  - One-word instruction visible at IF/ID 1 posedge after its PC is presented.
  - Two-word instruction visible 2 posedges after the opcode PC, with 1 bubble cycle.
- Arithmetic:
  - pc+1 computed at PC_W bits, wrapping modulo 2^PC_W; 32'hFFFFFFFF -> 0.
  - No sign extension in this stage.
- PC jumps between opcode and immediate fetch (e.g. an interrupt loading 0 or 31) are not legal without flush; the upstream control asserts flush in that cycle.
- A stall in SECOND holds op_hold; the immediate is taken on the first non-stalled posedge.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count[31:0] and output bubble_count[31:0].
  - Both reset to 0.
  - fetch_count increments on every posedge loading if_id_valid=1.
  - bubble_count increments on every non-stalled, non-reset posedge loading if_id_valid=0 (immediate bubble or flush).
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
- Reset low 2 cycles with imem_data=16'h1234 -> all IF/ID outputs 0/NOP, if_id_valid=0, pc_hold=0. Release with pc=32, imem_data=16'h1234 (bit0=0) -> next posedge instr=1234, imm=0, pc=32, next_pc=33, valid=1.
- Two-word: pc=40 with 16'h0501, then pc=41 with 16'hBEEF -> first posedge valid=0; second posedge instr=0501, imm=BEEF, pc=40, next_pc=42, valid=1.
- Stall: stall=1 for 3 cycles in SECOND (op 16'h0301 at pc=50) while pc held at 51 with imem_data=16'h00AA -> pc_hold=1 throughout and outputs frozen; after release instr=0301, imm=00AA, pc=50.
- Flush in SECOND: op 16'h0701 at pc=60, then flush=1 with stall=1 -> valid=0, NOP, pc_hold=0, state OPCODE. Next word 16'h0010 at pc=0 -> instr=0010, pc=0, valid=1.
- Wrap: pc=32'hFFFFFFFF, one-word instruction -> next_pc=0.
- With FETCH_PERF_CNT_EN, run 3 one-word instructions, 1 two-word instruction and 1 flush -> fetch_count=4, bubble_count=2.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction-fetch stage. Reads one 16-bit word per cycle at the
//             current PC, assembles one- or two-word instructions and loads
//             the IF/ID pipeline register. Drives pc_hold so the PC keeps its
//             address while fetch is stalled.
//  Options  : FETCH_PERF_CNT_EN adds fetch_count / bubble_count counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int               INSTR_W      = 16,
  parameter int               PC_W         = 32,
  parameter int               IMM_FLAG_BIT = 0,
  parameter logic [INSTR_W-1:0] NOP_WORD   = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  output logic               pc_hold,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_next_pc,
  output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  // OPCODE: expecting the first word of an instruction.
  // SECOND: opcode word captured, expecting its immediate word.
  typedef enum logic [0:0] {
    ST_OPCODE = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic [PC_W-1:0]    next_pc_q, next_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] op_hold_q, op_hold_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [PC_W-1:0]    pc_plus1;

  // PC is told to hold only for a genuine stall; flush wins, reset forces 0.
  assign pc_hold  = reset & stall & ~flush;
  assign pc_plus1 = pc + PC_W'(1);

  // Next-state and IF/ID load logic: flush > stall > normal fetch.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_out_d  = pc_out_q;
    next_pc_d = next_pc_q;
    valid_d   = valid_q;
    op_hold_d = op_hold_q;
    hold_pc_d = hold_pc_q;
    if (flush) begin
      // Squash: IF/ID becomes a bubble; addresses are kept for debug visibility.
      instr_d   = NOP_WORD;
      imm_d     = '0;
      valid_d   = 1'b0;
      op_hold_d = '0;
      state_d   = ST_OPCODE;
    end else if (!stall) begin
      case (state_q)
        ST_OPCODE: begin
          if (imem_data[IMM_FLAG_BIT]) begin
            // First half of a two-word instruction: park it, emit a bubble.
            op_hold_d = imem_data;
            hold_pc_d = pc;
            instr_d   = NOP_WORD;
            imm_d     = '0;
            valid_d   = 1'b0;
            state_d   = ST_SECOND;
          end else begin
            instr_d   = imem_data;
            imm_d     = '0;
            pc_out_d  = pc;
            next_pc_d = pc_plus1;
            valid_d   = 1'b1;
          end
        end
        ST_SECOND: begin
          // The immediate word is data; its flag bit carries no meaning here.
          instr_d   = op_hold_q;
          imm_d     = imem_data;
          pc_out_d  = hold_pc_q;
          next_pc_d = pc_plus1;
          valid_d   = 1'b1;
          state_d   = ST_OPCODE;
        end
        default: state_d = ST_OPCODE;
      endcase
    end
  end

  // State and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_OPCODE;
      instr_q   <= NOP_WORD;
      imm_q     <= '0;
      pc_out_q  <= '0;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
      op_hold_q <= '0;
      hold_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_out_q  <= pc_out_d;
      next_pc_q <= next_pc_d;
      valid_q   <= valid_d;
      op_hold_q <= op_hold_d;
      hold_pc_q <= hold_pc_d;
    end
  end

  assign if_id_instr   = instr_q;
  assign if_id_imm     = imm_q;
  assign if_id_pc      = pc_out_q;
  assign if_id_next_pc = next_pc_q;
  assign if_id_valid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_en;

  // IF/ID is written on every posedge that is not a plain stall.
  assign load_en = flush | ~stall;

  // Saturating counters of valid loads and bubble loads.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_en) begin
      if (valid_d) begin
        if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
        if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed self-checking bench for fetch_stage with an expected-
//             result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic        pc_hold;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_next_pc;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .imem_data    (imem_data),
    .stall        (stall),
    .flush        (flush),
    .pc_hold      (pc_hold),
    .if_id_instr  (if_id_instr),
    .if_id_imm    (if_id_imm),
    .if_id_pc     (if_id_pc),
    .if_id_next_pc(if_id_next_pc),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    bit          full;   // 0: only instr/valid are defined for this load
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] i, input logic [15:0] m,
                              input logic [31:0] p, input logic [31:0] n,
                              input logic v, input bit f);
    exp_t e;
    e.instr = i; e.imm = m; e.pc = p; e.npc = n; e.valid = v; e.full = f;
    return e;
  endfunction

  // One clock: drive at negedge, check pc_hold, then compare IF/ID after posedge.
  task automatic cycle(input string tag, input logic rst_n, input logic [31:0] p,
                       input logic [15:0] d, input logic s, input logic f,
                       input exp_t e, input logic exp_hold);
    exp_t x;
    @(negedge clk);
    reset = rst_n; pc = p; imem_data = d; stall = s; flush = f;
    sbq.push_back(e);
    #1 check({tag, ".pc_hold"}, {31'd0, pc_hold}, {31'd0, exp_hold});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, x.instr});
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, x.valid});
    if (x.full) begin
      check({tag, ".imm"},     {16'd0, if_id_imm}, {16'd0, x.imm});
      check({tag, ".pc"},      if_id_pc,           x.pc);
      check({tag, ".next_pc"}, if_id_next_pc,      x.npc);
    end
  endtask

  localparam logic [15:0] NOP = 16'h0000;

  initial begin
    reset = 1'b0; pc = '0; imem_data = 16'h1234; stall = 1'b0; flush = 1'b0;

    // Reset, second cycle with stall/flush asserted to show reset dominates.
    cycle("rst0", 1'b0, 32'd0, 16'h1234, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 1), 1'b0);
    cycle("rst1", 1'b0, 32'd0, 16'h1234, 1'b1, 1'b0, mk(NOP, 0, 0, 0, 0, 1), 1'b0);

    // One-word instruction.
    cycle("one", 1'b1, 32'd32, 16'h1234, 1'b0, 1'b0, mk(16'h1234, 0, 32, 33, 1, 1), 1'b0);

    // Two-word instruction; immediate has flag bit set and must not be decoded.
    cycle("two_a", 1'b1, 32'd40, 16'h0501, 1'b0, 1'b0, mk(NOP, 0, 0, 0, 0, 0), 1'b0);
    cycle("two_b", 1'b1, 32'd41, 16'hBEEF, 1'b0, 1'b0, mk(16'h0501, 16'hBEEF, 40, 42, 1, 1), 1'b0);

    // Stall in SECOND for 3 cycles: outputs stay frozen on the bubble.
    cycle("stl_a", 1'b1, 32'd50, 16'h0301, 1'b0, 1'b0, mk(NOP, 0, 40, 42, 0, 1), 1'b0);
    for (int k = 0; k < 3; k++)
      cycle("stl_h", 1'b1, 32'd51, 16'h00AA, 1'b1, 1'b0, mk(NOP, 0, 40, 42, 0, 1), 1'b1);
    cycle("stl_b", 1'b1, 32'd51, 16'h00AA, 1'b0, 1'b0, mk(16'h0301, 16'h00AA, 50, 52, 1, 1), 1'b0);

    // Flush (with stall) in SECOND drops the partial instruction.
    cycle("fl_a", 1'b1, 32'd60, 16'h0701, 1'b0, 1'b0, mk(NOP, 0, 50, 52, 0, 1), 1'b0);
    cycle("fl_b", 1'b1, 32'd61, 16'h5555, 1'b1, 1'b1, mk(NOP, 0, 50, 52, 0, 1), 1'b0);
    cycle("fl_c", 1'b1, 32'd0, 16'h0010, 1'b0, 1'b0, mk(16'h0010, 0, 0, 1, 1, 1), 1'b0);

    // PC wrap on next_pc.
    cycle("wrap", 1'b1, 32'hFFFF_FFFF, 16'h0002, 1'b0, 1'b0,
          mk(16'h0002, 0, 32'hFFFF_FFFF, 32'd0, 1, 1), 1'b0);

`ifdef FETCH_PERF_CNT_EN
    // Valid loads: 1234, 0501, 0301, 0010, 0002. Bubbles: 0501, 0301, 0701, flush.
    check("fetch_count",  fetch_count,  32'd5);
    check("bubble_count", bubble_count, 32'd4);
`endif

    check("sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence is short and fixed-length.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
